m_ifetch_q: RTL and testbench

Instruction-fetch stage with a prefetch queue for the 5-stage MIPS-subset pipeline. It drives the synchronous instruction memory, tags each returned word with its PC, and buffers up to DEPTH {pc, ir} entries. Entries go to the ID stage under a valid/ready handshake. ID-resolved branches redirect it, and the processor halt signal stops it.

---
 rtl/m_ifetch_q_if.sv | 35 +++
 rtl/m_ifetch_q.sv | 97 +++++++++
 tb/tb_m_ifetch_q.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/m_ifetch_q_if.sv
// m_ifetch_q_if: fetch-stage bus bundle (pipeline control, instruction memory port, ID handshake)
//   slave  : seen by m_ifetch_q (inputs w_*, outputs o_*)
//   master : seen by the surrounding pipeline / memory model
//   w_halt, w_redir, w_redir_pc   pipeline control
//   o_imem_addr, o_imem_re        memory request, w_imem_rdata one cycle later
//   o_valid, o_pc, o_pc4, o_ir    queue head towards ID, accepted by w_ready
//   o_count                       queue occupancy
interface m_ifetch_q_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          w_halt;
    logic          w_redir;
    logic [31:0]   w_redir_pc;
    logic [11:0]   o_imem_addr;
    logic          o_imem_re;
    logic [31:0]   w_imem_rdata;
    logic          o_valid;
    logic [31:0]   o_pc;
    logic [31:0]   o_pc4;
    logic [31:0]   o_ir;
    logic          w_ready;
    logic [CW-1:0] o_count;

    modport slave (
        input  w_halt, w_redir, w_redir_pc, w_imem_rdata, w_ready,
        output o_imem_addr, o_imem_re, o_valid, o_pc, o_pc4, o_ir, o_count
    );

    modport master (
        output w_halt, w_redir, w_redir_pc, w_imem_rdata, w_ready,
        input  o_imem_addr, o_imem_re, o_valid, o_pc, o_pc4, o_ir, o_count
    );
endinterface

// File: rtl/m_ifetch_q.sv
// m_ifetch_q: instruction fetch stage with a DEPTH-entry {pc, ir} prefetch queue
//   w_clk, w_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : halt/redirect control, synchronous imem port, valid/ready head to ID
//   Optional build macro IFQ_NOP_FILL_EN: while o_valid is low, o_ir reads NOP (0x20) and
//   o_pc/o_pc4 hold the last dequeued PC; otherwise they show stale head storage.
module m_ifetch_q #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    m_ifetch_q_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   tag_q, tag_d;
    logic          inflight_q, inflight_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q [DEPTH];
    logic [31:0]   ir_mem_q [DEPTH];
    logic          valid, deq, enq, issue;
    logic [31:0]   target;
    logic [31:0]   head_pc, head_ir;

    always_comb begin
        valid  = count_q != '0;
        deq    = valid & bus.w_ready;
        // credit counts the outstanding fetch; a pop this cycle frees nothing until next cycle
        issue  = w_rst_n & ~bus.w_halt & ~bus.w_redir
               & (int'(count_q) + int'(inflight_q) < DEPTH);
        // a redirect discards the response arriving this cycle
        enq    = inflight_q & ~bus.w_redir;
        target = bus.w_redir_pc & ~32'h3;
        head_d = deq ? head_q + AW'(1) : head_q;
        // flushing means collapsing the tail onto the post-pop head
        tail_d = bus.w_redir ? head_d : (enq ? tail_q + AW'(1) : tail_q);
        count_d = bus.w_redir ? '0 : count_q + CW'(enq) - CW'(deq);
        inflight_d = issue;
        tag_d  = issue ? pc_q : tag_q;
        pc_d   = bus.w_redir ? target : (issue ? pc_q + 32'd4 : pc_q);
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i] <= '0;
                ir_mem_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            if (enq) begin
                pc_mem_q[tail_q] <= tag_q;
                ir_mem_q[tail_q] <= bus.w_imem_rdata;
            end
        end
    end

`ifdef IFQ_NOP_FILL_EN
    logic [31:0] last_pc_q;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n)
            last_pc_q <= '0;
        else if (deq)
            last_pc_q <= pc_mem_q[head_q];
    end

    assign head_pc = valid ? pc_mem_q[head_q] : last_pc_q;
    assign head_ir = valid ? ir_mem_q[head_q] : 32'h0000_0020;
`else
    assign head_pc = pc_mem_q[head_q];
    assign head_ir = ir_mem_q[head_q];
`endif

    assign bus.o_imem_addr = pc_q[13:2];
    assign bus.o_imem_re   = issue;
    assign bus.o_valid     = valid;
    assign bus.o_count     = count_q;
    assign bus.o_pc        = head_pc;
    assign bus.o_pc4       = head_pc + 32'd4;
    assign bus.o_ir        = head_ir;
endmodule

// File: tb/tb_m_ifetch_q.sv
// tb_m_ifetch_q: directed bench for m_ifetch_q with a queue-level reference model
module tb_m_ifetch_q;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_on  = 1'b0;

    always #5 clk = ~clk;

    m_ifetch_q_if #(.DEPTH(DEPTH)) bus ();

    m_ifetch_q #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .w_clk   (clk),
        .w_rst_n (rst_n),
        .bus     (bus)
    );

    // instruction memory: word k holds k
    always_ff @(posedge clk)
        if (bus.o_imem_re) bus.w_imem_rdata <= {20'h0, bus.o_imem_addr};

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: in-order list of {pc, ir} entries, next PC, one outstanding fetch
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc   = RESET_PC;
    logic [31:0] m_tag  = 32'h0;
    logic [31:0] m_last = 32'h0;
    bit          m_infl = 1'b0;

    always @(negedge rst_n) begin
        mq.delete();
        m_pc   = RESET_PC;
        m_tag  = 32'h0;
        m_last = 32'h0;
        m_infl = 1'b0;
    end

    always @(posedge clk) begin
        bit dq, is;
        if (rst_n) begin
            dq = mq.size() > 0 && bus.w_ready;
            is = !bus.w_halt && !bus.w_redir && (mq.size() + int'(m_infl) < DEPTH);
            if (dq) begin
                m_last = mq[0].pc;
                void'(mq.pop_front());
            end
            if (bus.w_redir) begin
                mq.delete();
                m_infl = 1'b0;
                m_pc   = bus.w_redir_pc & ~32'h3;
            end else begin
                if (m_infl) mq.push_back('{m_tag, {20'h0, m_tag[13:2]}});
                m_infl = is;
                if (is) begin
                    m_tag = m_pc;
                    m_pc  = m_pc + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("m_valid", {31'h0, bus.o_valid}, {31'h0, mq.size() > 0});
            cmp("m_count", 32'(bus.o_count), 32'(mq.size()));
            cmp("m_re", {31'h0, bus.o_imem_re},
                {31'h0, rst_n && !bus.w_halt && !bus.w_redir && (mq.size() + int'(m_infl) < DEPTH)});
            cmp("m_addr", {20'h0, bus.o_imem_addr}, {20'h0, m_pc[13:2]});
            if (mq.size() > 0) begin
                cmp("m_pc", bus.o_pc, mq[0].pc);
                cmp("m_pc4", bus.o_pc4, mq[0].pc + 32'd4);
                cmp("m_ir", bus.o_ir, mq[0].ir);
            end
`ifdef IFQ_NOP_FILL_EN
            else begin
                cmp("m_nop_ir", bus.o_ir, 32'h0000_0020);
                cmp("m_nop_pc", bus.o_pc, m_last);
                cmp("m_nop_pc4", bus.o_pc4, m_last + 32'd4);
            end
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic head(input string name, input logic [31:0] pc, input logic [31:0] ir);
        cmp({name, "_valid"}, {31'h0, bus.o_valid}, 32'h1);
        cmp({name, "_pc"}, bus.o_pc, pc);
        cmp({name, "_ir"}, bus.o_ir, ir);
    endtask

    task automatic empty(input string name);
        cmp({name, "_valid"}, {31'h0, bus.o_valid}, 32'h0);
`ifdef IFQ_NOP_FILL_EN
        cmp({name, "_nop"}, bus.o_ir, 32'h0000_0020);
`endif
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.w_halt     = 1'b0;
        bus.w_redir    = 1'b0;
        bus.w_redir_pc = 32'h0;
        bus.w_ready    = 1'b0;
        #1;
        chk_on = 1'b1;
        cmp("rst_valid", {31'h0, bus.o_valid}, 32'h0);
        cmp("rst_count", 32'(bus.o_count), 32'h0);
        cmp("rst_re", {31'h0, bus.o_imem_re}, 32'h0);
        cmp("rst_addr", {20'h0, bus.o_imem_addr}, 32'h0);
        cmp("rst_pc", bus.o_pc, 32'h0);
        cmp("rst_pc4", bus.o_pc4, 32'h4);
`ifdef IFQ_NOP_FILL_EN
        cmp("rst_ir", bus.o_ir, 32'h20);
`else
        cmp("rst_ir", bus.o_ir, 32'h0);
`endif
        repeat (2) step();

        // free run from reset
        bus.w_ready = 1'b1;
        rst_n = 1'b1;
        #1 cmp("rel_re", {31'h0, bus.o_imem_re}, 32'h1);
        step();
        empty("lat1");
        step();
        head("first", 32'h0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step();
            head("run", 32'(4 * i), 32'(i));
        end

        // redirect with 0x10 at the head being consumed
        bus.w_redir    = 1'b1;
        bus.w_redir_pc = 32'h43;
        step();
        bus.w_redir = 1'b0;
        empty("redir_r1");
        step();
        empty("redir_r2");
        step();
        head("redir_r3", 32'h40, 32'h10);
        cmp("redir_pc4", bus.o_pc4, 32'h44);
        step();
        head("redir_r4", 32'h44, 32'h11);
        step();
        head("redir_r5", 32'h48, 32'h12);

        // backpressure
        bus.w_ready = 1'b0;
        repeat (10) step();
        cmp("bp_count", 32'(bus.o_count), 32'd4);
        cmp("bp_re", {31'h0, bus.o_imem_re}, 32'h0);
        head("bp_head", 32'h48, 32'h12);
        bus.w_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            head("bp_pop", 32'h48 + 32'(4 * k), 32'h12 + 32'(k));
            step();
        end

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        cmp("arst_valid", {31'h0, bus.o_valid}, 32'h0);
        cmp("arst_count", 32'(bus.o_count), 32'h0);
        cmp("arst_re", {31'h0, bus.o_imem_re}, 32'h0);
        cmp("arst_addr", {20'h0, bus.o_imem_addr}, 32'h0);
        repeat (2) step();
        bus.w_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        cmp("arst_rel_re", {31'h0, bus.o_imem_re}, 32'h1);
        cmp("arst_rel_addr", {20'h0, bus.o_imem_addr}, 32'h0);

        // halt with three queued and one in flight
        repeat (4) step();
        cmp("pre_halt_count", 32'(bus.o_count), 32'd3);
        cmp("pre_halt_re", {31'h0, bus.o_imem_re}, 32'h0);
        bus.w_halt  = 1'b1;
        bus.w_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            head("halt_drain", 32'(4 * k), 32'(k));
            step();
        end
        empty("halt_empty");
        cmp("halt_count", 32'(bus.o_count), 32'h0);
        cmp("halt_re", {31'h0, bus.o_imem_re}, 32'h0);
        step();
        empty("halt_hold");
        cmp("halt_addr", {20'h0, bus.o_imem_addr}, 32'h4);
        bus.w_halt = 1'b0;
        #1 cmp("resume_re", {31'h0, bus.o_imem_re}, 32'h1);
        step();
        step();
        head("resume", 32'h10, 32'h4);

        // halt and redirect together, target near the top of the address space
        bus.w_halt     = 1'b1;
        bus.w_redir    = 1'b1;
        bus.w_redir_pc = 32'hFFFF_FFFA;
        #1 cmp("hr_re", {31'h0, bus.o_imem_re}, 32'h0);
        step();
        bus.w_redir = 1'b0;
        empty("hr_flush");
        cmp("hr_count", 32'(bus.o_count), 32'h0);
        cmp("hr_addr", {20'h0, bus.o_imem_addr}, 32'hFFE);
        step();
        empty("hr_hold");
        bus.w_halt = 1'b0;
        step();
        step();
        head("wrap0", 32'hFFFF_FFF8, 32'hFFE);
        step();
        head("wrap1", 32'hFFFF_FFFC, 32'hFFF);
        cmp("wrap1_pc4", bus.o_pc4, 32'h0);
        step();
        head("wrap2", 32'h0, 32'h0);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
